branch_predictor: RTL and testbench
===================================

# branch_predictor

IF-stage branch predictor paired with the ID-stage early branch comparator. Each cycle it predicts direction and target for the fetch PC from a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. When ID resolves a conditional branch, the predictor updates the BTB and raises a one-cycle mispredict/redirect that flushes IF. It also keeps branch and mispredict statistics counters.

## Interface

Parameters:
- ENTRIES, 16, BTB entries; power of two, 2..256
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock, one reset for the whole block
- IF_PC  in  32  current fetch PC (word aligned)
- IF_Predict  out  1  predicted taken for IF_PC
- IF_Target  out  32  next fetch PC: BTB target if IF_Predict, else IF_PC+4
- ID_Valid  in  1  ID holds a conditional branch resolved this cycle
- ID_Stall  in  1  ID stalled; resolution not committed this cycle
- ID_PC  in  32  PC of the branch in ID
- ID_Target  in  32  taken target computed in ID
- ID_Branch  in  1  actual outcome from the ID comparator
- ID_Predicted  in  1  IF_Predict value piped to ID with the instruction
- Mispredict  out  1  committed resolution disagrees with prediction
- Redirect_PC  out  32  correct next PC while Mispredict=1
- Flush_IF  out  1  kill the instruction in IF; equals Mispredict
- BranchCount  out  32  committed branches since reset
- MispredictCount  out  32  committed mispredicts since reset

## Operation

- Entry: valid(1), tag = PC[31:IDX_W+2], target(32), ctr(2). Index = PC[IDX_W+1:2].
- Lookup is combinational: hit = valid && tag match at IF_PC index; IF_Predict = hit && ctr[1]; IF_Target = IF_Predict ? target : IF_PC+4.
- Commit = ID_Valid && !ID_Stall. No state changes unless commit (reset excepted).
- On commit, at ID_PC index:
  - hit, taken: ctr saturating +1 (max 11); target <= ID_Target.
  - hit, not taken: ctr saturating −1 (min 00); target unchanged.
  - miss, taken: allocate/overwrite: valid=1, tag, target=ID_Target, ctr=10.
  - miss, not taken: no write.
- Mispredict = commit && (ID_Branch != ID_Predicted), combinational. Redirect_PC = ID_Branch ? ID_Target : ID_PC+4; Redirect_PC is 0 while Mispredict=0.
- Counters: on commit BranchCount +1; on Mispredict MispredictCount +1. Both saturate at 32'hFFFFFFFF.
- Arithmetic: PC+4 is 32-bit modulo and wraps 32'hFFFFFFFC -> 0.

## Timing

- Reset: all valid=0, all ctr=01, targets=0, both counters=0. IF_Predict=0, IF_Target=IF_PC+4, Mispredict=Flush_IF=0, Redirect_PC=0.
- Reset has priority over a same-cycle commit; that commit is dropped.
- Lookup: zero latency, same cycle as IF_PC.
- Update: visible to lookup on the cycle after the commit edge.
- Same-cycle IF lookup and commit to one index: IF sees the pre-update entry (read-before-write).
- Mispredict/Flush_IF: same cycle as commit, never more than one cycle per committed branch.
- ID_Stall=1 with ID_Valid=1: no update, no Mispredict, no count. The branch commits on the first unstalled cycle.
- Commits on consecutive cycles to the same index both apply in order.

## Structure

- Shared package: ENTRIES default; counter encodings SNT=00, WNT=01, WT=10, ST=11; ALLOC_CTR=WT; RESET_CTR=WNT; PC_INC=4.
- Sub-module `sat_counter2`: combinational 2-bit next-state (ctr, taken) -> ctr'. It is instantiated once for the committing entry.
- BTB is flop arrays, not inferred RAM, because the lookup is asynchronous.

## Test plan

- Reset, then IF_PC=0x00400010 -> IF_Predict=0, IF_Target=0x00400014. Counters 0.
- Commit ID_PC=0x00400010, taken, ID_Target=0x00400040, ID_Predicted=0 -> Mispredict=1, Redirect_PC=0x00400040. Next cycle, IF_PC=0x00400010 -> IF_Predict=1, IF_Target=0x00400040, ctr=10.
- Four taken commits, then two not-taken commits on the same PC -> ctr 11 (saturated), then 10, then 01. Predict=0 after the second not-taken. The not-taken commits with ID_Predicted=1 produce Redirect_PC=ID_PC+4.
- Aliasing (ENTRIES=16): allocate 0x00400010, then commit taken 0x00400050 (same index) -> 0x00400010 misses and predicts 0; 0x00400050 hits.
- ID_Valid=1 with ID_Stall=1 for 3 cycles, then ID_Stall=0 -> exactly one update, one BranchCount increment, and Mispredict only on the unstalled cycle. Reset asserted during a commit cycle -> no update, counters 0.
- Same-cycle lookup and commit at the same index -> IF_Predict reflects the old ctr. Next cycle reflects the new ctr.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch predictor: counter encodings,
// reset/allocation values and small arithmetic helpers.
package branch_predictor_pkg;

    localparam int ENTRIES_DEFAULT = 16;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e        ALLOC_CTR = CTR_WT;
    localparam ctr_e        RESET_CTR = CTR_WNT;
    localparam logic [31:0] PC_INC    = 32'd4;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctr = i_ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor: asynchronous lookup for IF, update and
// redirect on committed ID resolutions, plus branch/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_PC,
    output logic        IF_Predict,
    output logic [31:0] IF_Target,
    input  logic        ID_Valid,
    input  logic        ID_Stall,
    input  logic [31:0] ID_PC,
    input  logic [31:0] ID_Target,
    input  logic        ID_Branch,
    input  logic        ID_Predicted,
    output logic        Mispredict,
    output logic [31:0] Redirect_PC,
    output logic        Flush_IF,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Flop arrays so that the IF lookup can be purely combinational.
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_id_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [TAG_W-1:0] w_id_tag;
    logic             w_if_hit;
    logic             w_id_hit;
    logic             w_commit;
    logic             w_mispredict;
    logic [1:0]       w_ctr_next;
    logic [31:0]      w_if_pc_inc;
    logic [31:0]      w_id_pc_inc;
    logic             w_unused_pc_bits;

    assign w_if_idx = IF_PC[IDX_W+1:2];
    assign w_if_tag = IF_PC[31:IDX_W+2];
    assign w_id_idx = ID_PC[IDX_W+1:2];
    assign w_id_tag = ID_PC[31:IDX_W+2];

    assign w_if_pc_inc = IF_PC + PC_INC;
    assign w_id_pc_inc = ID_PC + PC_INC;

    assign w_unused_pc_bits = ^{IF_PC[1:0], ID_PC[1:0]};

    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

    // ID hands over a resolution when ID_Valid is high and ID_Stall is low;
    // a stalled branch simply re-presents itself until that cycle. A commit
    // coinciding with reset is dropped, so it cannot flag a mispredict either.
    assign w_commit     = ID_Valid && !ID_Stall && !reset;
    assign w_mispredict = w_commit && (ID_Branch != ID_Predicted);

    assign IF_Predict  = w_if_hit && r_ctr[w_if_idx][1];
    assign IF_Target   = IF_Predict ? r_target[w_if_idx] : w_if_pc_inc;

    assign Mispredict  = w_mispredict;
    assign Flush_IF    = w_mispredict;
    assign Redirect_PC = !w_mispredict ? 32'd0 :
                         (ID_Branch ? ID_Target : w_id_pc_inc);

    assign BranchCount     = r_branch_count;
    assign MispredictCount = r_mispredict_count;

    sat_counter2 u_sat_counter2 (
        .i_ctr   (r_ctr[w_id_idx]),
        .i_taken (ID_Branch),
        .o_ctr   (w_ctr_next)
    );

    // Lookup reads the arrays before this edge, so a same-cycle IF access to
    // the committing index sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= RESET_CTR;
            end
        end else if (w_commit) begin
            if (w_id_hit) begin
                r_ctr[w_id_idx] <= w_ctr_next;
                if (ID_Branch) begin
                    r_target[w_id_idx] <= ID_Target;
                end
            end else if (ID_Branch) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= ID_Target;
                r_ctr[w_id_idx]    <= ALLOC_CTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= 32'd0;
            r_mispredict_count <= 32'd0;
        end else begin
            if (w_commit) begin
                r_branch_count <= sat_inc32(r_branch_count);
            end
            if (w_mispredict) begin
                r_mispredict_count <= sat_inc32(r_mispredict_count);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16) with a reference model
// feeding an expected-result queue.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] IF_PC;
    logic        IF_Predict;
    logic [31:0] IF_Target;
    logic        ID_Valid;
    logic        ID_Stall;
    logic [31:0] ID_PC;
    logic [31:0] ID_Target;
    logic        ID_Branch;
    logic        ID_Predicted;
    logic        Mispredict;
    logic [31:0] Redirect_PC;
    logic        Flush_IF;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    int checks   = 0;
    int failures = 0;

    // {predict, target, mispredict, redirect, flush}
    logic [66:0] exp_q[$];
    logic [66:0] obs_q[$];
    logic [66:0] exp_v;
    logic [66:0] got_v;

    logic        obs_pred;
    logic [31:0] obs_tgt;
    logic        obs_misp;
    logic [31:0] obs_redir;
    logic        obs_flush;

    // Reference model
    logic        m_valid  [16];
    logic [25:0] m_tag    [16];
    logic [31:0] m_target [16];
    logic [1:0]  m_ctr    [16];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .IF_PC           (IF_PC),
        .IF_Predict      (IF_Predict),
        .IF_Target       (IF_Target),
        .ID_Valid        (ID_Valid),
        .ID_Stall        (ID_Stall),
        .ID_PC           (ID_PC),
        .ID_Target       (ID_Target),
        .ID_Branch       (ID_Branch),
        .ID_Predicted    (ID_Predicted),
        .Mispredict      (Mispredict),
        .Redirect_PC     (Redirect_PC),
        .Flush_IF        (Flush_IF),
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = 32'd0;
            m_ctr[i]    = 2'b01;
        end
        m_bcnt = 32'd0;
        m_mcnt = 32'd0;
    endfunction

    function automatic logic [66:0] model_expect(input logic [31:0] if_pc, input logic commit,
                                                 input logic [31:0] id_pc, input logic [31:0] id_tgt,
                                                 input logic br, input logic pr);
        logic [3:0]  idx;
        logic        pred;
        logic [31:0] tgt;
        logic        misp;
        logic [31:0] redir;
        idx   = if_pc[5:2];
        pred  = m_valid[idx] && (m_tag[idx] == if_pc[31:6]) && (m_ctr[idx] >= 2'b10);
        tgt   = pred ? m_target[idx] : if_pc + 32'd4;
        misp  = commit && (br != pr);
        redir = 32'd0;
        if (misp) redir = br ? id_tgt : id_pc + 32'd4;
        return {pred, tgt, misp, redir, misp};
    endfunction

    function automatic void model_commit(input logic [31:0] id_pc, input logic [31:0] id_tgt,
                                         input logic br, input logic pr);
        logic [3:0] idx;
        idx = id_pc[5:2];
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
        if (br != pr && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
        if (m_valid[idx] && m_tag[idx] == id_pc[31:6]) begin
            if (br) begin
                m_target[idx] = id_tgt;
                if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
            end else if (m_ctr[idx] != 2'b00) begin
                m_ctr[idx] = m_ctr[idx] - 2'b01;
            end
        end else if (br) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = id_pc[31:6];
            m_target[idx] = id_tgt;
            m_ctr[idx]    = 2'b10;
        end
    endfunction

    // Drives one cycle starting just after a rising edge; queues the expected
    // outputs, captures observed outputs on the falling edge, then advances.
    task automatic run_cycle(input logic rst, input logic [31:0] if_pc, input logic valid,
                             input logic stall, input logic [31:0] id_pc, input logic [31:0] id_tgt,
                             input logic br, input logic pr);
        logic commit;
        reset        = rst;
        IF_PC        = if_pc;
        ID_Valid     = valid;
        ID_Stall     = stall;
        ID_PC        = id_pc;
        ID_Target    = id_tgt;
        ID_Branch    = br;
        ID_Predicted = pr;
        commit = valid && !stall && !rst;
        exp_q.push_back(model_expect(if_pc, commit, id_pc, id_tgt, br, pr));
        @(negedge clk);
        obs_pred  = IF_Predict;
        obs_tgt   = IF_Target;
        obs_misp  = Mispredict;
        obs_redir = Redirect_PC;
        obs_flush = Flush_IF;
        obs_q.push_back({obs_pred, obs_tgt, obs_misp, obs_redir, obs_flush});
        @(posedge clk);
        if (rst) model_reset();
        else if (commit) model_commit(id_pc, id_tgt, br, pr);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; IF_PC = 32'h0; ID_Valid = 1'b0; ID_Stall = 1'b0;
        ID_PC = 32'h0; ID_Target = 32'h0; ID_Branch = 1'b0; ID_Predicted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        run_cycle(1'b0, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_pred !== 1'b0) begin failures++; $display("FAIL reset_predict: got %0b expected 0", obs_pred); end
        checks++; if (obs_tgt !== 32'h0040_0014) begin failures++; $display("FAIL reset_target: got %h expected 00400014", obs_tgt); end
        checks++; if ({obs_misp, obs_flush, obs_redir} !== 34'd0) begin failures++; $display("FAIL reset_redirect: got %b/%b/%h expected 0/0/0", obs_misp, obs_flush, obs_redir); end
        checks++; if ({BranchCount, MispredictCount} !== 64'd0) begin failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", BranchCount, MispredictCount); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL reset_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_allocate();
        run_cycle(1'b0, 32'h0040_0100, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0040, 1'b1, 1'b0);
        checks++; if ({obs_misp, obs_redir} !== {1'b1, 32'h0040_0040}) begin failures++; $display("FAIL alloc_redirect: got %b/%h expected 1/00400040", obs_misp, obs_redir); end
        run_cycle(1'b0, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if ({obs_pred, obs_tgt} !== {1'b1, 32'h0040_0040}) begin failures++; $display("FAIL alloc_lookup: got %b/%h expected 1/00400040", obs_pred, obs_tgt); end
        checks++; if ({BranchCount, MispredictCount} !== {m_bcnt, m_mcnt}) begin failures++; $display("FAIL alloc_counters: got %0d/%0d expected %0d/%0d", BranchCount, MispredictCount, m_bcnt, m_mcnt); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL alloc_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++)
            run_cycle(1'b0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0040, 1'b1, 1'b1);
        run_cycle(1'b0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0040, 1'b0, 1'b1);
        checks++; if ({obs_misp, obs_redir} !== {1'b1, 32'h0040_0014}) begin failures++; $display("FAIL sat_nt_redirect: got %b/%h expected 1/00400014", obs_misp, obs_redir); end
        run_cycle(1'b0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0040, 1'b0, 1'b1);
        checks++; if (obs_pred !== 1'b1) begin failures++; $display("FAIL sat_after_one_nt: got %b expected 1", obs_pred); end
        run_cycle(1'b0, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if ({obs_pred, obs_tgt} !== {1'b0, 32'h0040_0014}) begin failures++; $display("FAIL sat_after_two_nt: got %b/%h expected 0/00400014", obs_pred, obs_tgt); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL sat_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_alias();
        run_cycle(1'b0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0050, 32'h0040_0080, 1'b1, 1'b0);
        run_cycle(1'b0, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_pred !== 1'b0) begin failures++; $display("FAIL alias_old_pc: got %b expected 0", obs_pred); end
        run_cycle(1'b0, 32'h0040_0050, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if ({obs_pred, obs_tgt} !== {1'b1, 32'h0040_0080}) begin failures++; $display("FAIL alias_new_pc: got %b/%h expected 1/00400080", obs_pred, obs_tgt); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL alias_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] b0;
        int          stalled_misp;
        b0 = BranchCount;
        stalled_misp = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0200, 32'h0040_0300, 1'b1, 1'b0);
            stalled_misp += int'(obs_misp);
        end
        checks++; if (stalled_misp != 0) begin failures++; $display("FAIL stall_misp: got %0d expected 0", stalled_misp); end
        checks++; if (BranchCount !== b0) begin failures++; $display("FAIL stall_count: got %0d expected %0d", BranchCount, b0); end
        run_cycle(1'b0, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0200, 32'h0040_0300, 1'b1, 1'b0);
        checks++; if (obs_misp !== 1'b1) begin failures++; $display("FAIL stall_release_misp: got %b expected 1", obs_misp); end
        checks++; if (BranchCount !== b0 + 32'd1) begin failures++; $display("FAIL stall_release_count: got %0d expected %0d", BranchCount, b0 + 32'd1); end
        run_cycle(1'b0, 32'h0040_0200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL stall_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_reset_commit();
        run_cycle(1'b1, 32'h0040_0200, 1'b1, 1'b0, 32'h0040_0240, 32'h0040_0400, 1'b1, 1'b0);
        checks++; if (obs_misp !== 1'b0) begin failures++; $display("FAIL rstc_misp: got %b expected 0", obs_misp); end
        run_cycle(1'b0, 32'h0040_0240, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_pred !== 1'b0) begin failures++; $display("FAIL rstc_lookup: got %b expected 0", obs_pred); end
        checks++; if ({BranchCount, MispredictCount} !== 64'd0) begin failures++; $display("FAIL rstc_counters: got %0d/%0d expected 0/0", BranchCount, MispredictCount); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL rstc_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        run_cycle(1'b0, 32'h0040_0000, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0070, 1'b1, 1'b0);
        run_cycle(1'b0, 32'h0040_0030, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0070, 1'b0, 1'b1);
        checks++; if (obs_pred !== 1'b1) begin failures++; $display("FAIL b2b_read_before_write: got %b expected 1", obs_pred); end
        run_cycle(1'b0, 32'h0040_0030, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0070, 1'b0, 1'b0);
        checks++; if ({obs_pred, obs_misp} !== 2'b00) begin failures++; $display("FAIL b2b_new_ctr: got %b/%b expected 0/0", obs_pred, obs_misp); end
        run_cycle(1'b0, 32'h0040_0000, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0080, 1'b1, 1'b0);
        run_cycle(1'b0, 32'h0040_0000, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0090, 1'b1, 1'b0);
        run_cycle(1'b0, 32'h0040_0030, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if ({obs_pred, obs_tgt} !== {1'b1, 32'h0040_0090}) begin failures++; $display("FAIL b2b_in_order: got %b/%h expected 1/00400090", obs_pred, obs_tgt); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL b2b_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_wrap();
        run_cycle(1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 1'b1);
        checks++; if ({obs_pred, obs_tgt} !== {1'b0, 32'h0}) begin failures++; $display("FAIL wrap_if_target: got %b/%h expected 0/00000000", obs_pred, obs_tgt); end
        checks++; if ({obs_misp, obs_redir} !== {1'b1, 32'h0}) begin failures++; $display("FAIL wrap_redirect: got %b/%h expected 1/00000000", obs_misp, obs_redir); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL wrap_sb: got %h expected %h", got_v, exp_v); end
        end
    endtask

    task automatic test_random();
        logic [31:0] pcs [8];
        logic [31:0] id_pc;
        pcs[0] = 32'h0040_0000; pcs[1] = 32'h0040_0004; pcs[2] = 32'h0040_0040;
        pcs[3] = 32'h0040_0044; pcs[4] = 32'h0080_0000; pcs[5] = 32'h0040_0080;
        pcs[6] = 32'hFFFF_FFFC; pcs[7] = 32'h0000_003C;
        for (int i = 0; i < 300; i++) begin
            id_pc = pcs[$urandom_range(0, 7)];
            run_cycle(($urandom_range(0, 49) == 0), pcs[$urandom_range(0, 7)],
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), id_pc,
                      $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front(); got_v = obs_q.pop_front(); checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL random_sb: got %h expected %h", got_v, exp_v); end
        end
        checks++; if ({BranchCount, MispredictCount} !== {m_bcnt, m_mcnt}) begin failures++; $display("FAIL random_counters: got %0d/%0d expected %0d/%0d", BranchCount, MispredictCount, m_bcnt, m_mcnt); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturate();
        test_alias();
        test_stall();
        test_reset_commit();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
